// File: rtl/logic_unit_pipe.sv
// Registered bitwise logic unit with pairwise and multi-beat reduction modes.
// Valid/ready on both sides, one output register, async active-high reset.
module logic_unit_pipe #(
  parameter int WIDTH = 8,
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  input  logic             mode,
  input  logic [LEN_W-1:0] len,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic [2:0]       y_last_op
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t state, state_nx;

  logic [WIDTH-1:0] acc, acc_nx;
  logic [WIDTH-1:0] acc_step;
  logic [WIDTH-1:0] y_nx;
  logic [LEN_W-1:0] cnt, cnt_nx;
  logic [LEN_W-1:0] cnt_inc;
  logic [LEN_W-1:0] len_r, len_nx;
  logic [LEN_W-1:0] len_eff;
  logic [2:0]       op_r, op_nx;
  logic [2:0]       yop_nx;
  logic             ov_nx;
  logic             beat;
  logic             out_free;

  function automatic logic [WIDTH-1:0] f_pair(
    input logic [2:0]       o,
    input logic [WIDTH-1:0] x,
    input logic [WIDTH-1:0] z
  );
    logic [WIDTH-1:0] r;
    r = x;
    case (o)
      3'd0:    r = x & z;
      3'd1:    r = x | z;
      3'd2:    r = ~(x & z);
      3'd3:    r = ~(x | z);
      3'd4:    r = x ^ z;
      3'd5:    r = ~(x ^ z);
      3'd6:    r = ~x;
      default: r = x;
    endcase
    return r;
  endfunction

  // Reduction folds with the base op; inversion applies only at the end.
  function automatic logic [WIDTH-1:0] f_base(
    input logic [2:0]       o,
    input logic [WIDTH-1:0] x,
    input logic [WIDTH-1:0] z
  );
    logic [WIDTH-1:0] r;
    r = x ^ z;
    case (o)
      3'd0, 3'd2: r = x & z;
      3'd1, 3'd3: r = x | z;
      default:    r = x ^ z;
    endcase
    return r;
  endfunction

  function automatic logic [WIDTH-1:0] f_fin(
    input logic [2:0]       o,
    input logic [WIDTH-1:0] x
  );
    logic [WIDTH-1:0] r;
    r = x;
    case (o)
      3'd2, 3'd3, 3'd5: r = ~x;
      default:          r = x;
    endcase
    return r;
  endfunction

  assign out_free = !out_valid || out_ready;
  assign in_ready = (state != HOLD) && out_free;
  assign beat     = in_valid && in_ready;
  assign acc_step = f_base(op_r, acc, a);
  assign cnt_inc  = cnt + LEN_W'(1);
  assign len_eff  = (len == '0) ? LEN_W'(1) : len;

  always_comb begin
    state_nx = state;
    acc_nx   = acc;
    cnt_nx   = cnt;
    len_nx   = len_r;
    op_nx    = op_r;
    y_nx     = y;
    yop_nx   = y_last_op;
    ov_nx    = out_valid && !out_ready;
    case (state)
      IDLE: begin
        if (beat) begin
          if (!mode || op[2:1] == 2'b11) begin
            y_nx   = f_pair(op, a, b);
            yop_nx = op;
            ov_nx  = 1'b1;
          end else begin
            op_nx  = op;
            len_nx = len_eff;
            acc_nx = a;
            cnt_nx = LEN_W'(1);
            if (len_eff == LEN_W'(1)) begin
              y_nx   = f_fin(op, a);
              yop_nx = op;
              ov_nx  = 1'b1;
            end else begin
              state_nx = ACCUM;
            end
          end
        end
      end
      ACCUM: begin
        if (beat) begin
          acc_nx = acc_step;
          cnt_nx = cnt_inc;
          if (cnt_inc == len_r) begin
            if (out_free) begin
              y_nx     = f_fin(op_r, acc_step);
              yop_nx   = op_r;
              ov_nx    = 1'b1;
              state_nx = IDLE;
            end else begin
              state_nx = HOLD;
            end
          end
        end
      end
      HOLD: begin
        if (out_free) begin
          y_nx     = f_fin(op_r, acc);
          yop_nx   = op_r;
          ov_nx    = 1'b1;
          state_nx = IDLE;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      len_r     <= '0;
      op_r      <= '0;
      y         <= '0;
      y_last_op <= '0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nx;
      acc       <= acc_nx;
      cnt       <= cnt_nx;
      len_r     <= len_nx;
      op_r      <= op_nx;
      y         <= y_nx;
      y_last_op <= yop_nx;
      out_valid <= ov_nx;
    end
  end

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Directed and random bench for logic_unit_pipe against a queue-based
// transaction model of pairwise and reduction results.
module tb_logic_unit_pipe;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic [2:0] op;
  logic       mode;
  logic [3:0] len;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] y;
  logic [2:0] y_last_op;

  logic_unit_pipe #(.WIDTH(8), .LEN_W(4)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .a(a),
    .b(b),
    .op(op),
    .mode(mode),
    .len(len),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .y(y),
    .y_last_op(y_last_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] y;
    logic [2:0] op;
  } res_t;

  res_t       q[$];
  logic [7:0] beats[$];
  bit         in_red;
  int         red_len;
  logic [2:0] red_op;
  int         n_cmp;
  int         n_bad;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] ref_pair(input logic [2:0] o,
                                          input logic [7:0] x,
                                          input logic [7:0] z);
    case (o)
      3'd0:    return x & z;
      3'd1:    return x | z;
      3'd2:    return ~(x & z);
      3'd3:    return ~(x | z);
      3'd4:    return x ^ z;
      3'd5:    return ~(x ^ z);
      3'd6:    return ~x;
      default: return x;
    endcase
  endfunction

  function automatic logic [7:0] ref_reduce(input logic [2:0] o);
    logic [7:0] r;
    r = beats[0];
    for (int i = 1; i < beats.size(); i++) begin
      if (o == 3'd0 || o == 3'd2)      r = r & beats[i];
      else if (o == 3'd1 || o == 3'd3) r = r | beats[i];
      else                             r = r ^ beats[i];
    end
    if (o == 3'd2 || o == 3'd3 || o == 3'd5) r = ~r;
    return r;
  endfunction

  task automatic model_beat(input logic [7:0] ia, input logic [7:0] ib,
                            input logic [2:0] iop, input bit im,
                            input logic [3:0] il);
    if (!in_red) begin
      if (!im || iop >= 3'd6) begin
        q.push_back('{ref_pair(iop, ia, ib), iop});
      end else begin
        red_op  = iop;
        red_len = (il == 0) ? 1 : int'(il);
        beats.delete();
        beats.push_back(ia);
        in_red = 1'b1;
      end
    end else begin
      beats.push_back(ia);
    end
    if (in_red && beats.size() == red_len) begin
      q.push_back('{ref_reduce(red_op), red_op});
      in_red = 1'b0;
    end
  endtask

  task automatic step(input bit iv, input logic [7:0] ia,
                      input logic [7:0] ib, input logic [2:0] iop,
                      input bit im, input logic [3:0] il, input bit ordy);
    bit exp_rdy;
    bit acc_b;
    bit take_b;
    @(negedge clk);
    in_valid  = iv;
    a         = ia;
    b         = ib;
    op        = iop;
    mode      = im;
    len       = il;
    out_ready = ordy;
    #1;
    exp_rdy = (q.size() == 0) || ordy;
    chk("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
    if (q.size() != 0) begin
      chk("y", {24'd0, y}, {24'd0, q[0].y});
      chk("y_last_op", {29'd0, y_last_op}, {29'd0, q[0].op});
    end
    acc_b  = iv && exp_rdy;
    take_b = (q.size() != 0) && ordy;
    @(posedge clk);
    #1;
    if (take_b) void'(q.pop_front());
    if (acc_b) model_beat(ia, ib, iop, im, il);
    chk("out_valid", {31'd0, out_valid}, {31'd0, q.size() != 0});
  endtask

  task automatic async_reset();
    @(negedge clk);
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_y", {24'd0, y}, 32'd0);
    chk("rst_y_last_op", {29'd0, y_last_op}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    q.delete();
    beats.delete();
    in_red = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  logic [7:0] y_hold;

  initial begin
    n_cmp     = 0;
    n_bad     = 0;
    in_red    = 1'b0;
    rst       = 1'b0;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    op        = '0;
    mode      = 1'b0;
    len       = '0;
    out_ready = 1'b1;
    #1;
    rst = 1'b1;
    #2;
    chk("init_out_valid", {31'd0, out_valid}, 32'd0);
    chk("init_y", {24'd0, y}, 32'd0);
    chk("init_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b0;

    // pairwise NAND, NOR, XOR
    step(1, 8'hF0, 8'h3C, 3'd2, 0, 4'd0, 1);
    chk("nand", {24'd0, y}, 32'hCF);
    step(1, 8'hF0, 8'h3C, 3'd3, 0, 4'd0, 1);
    chk("nor", {24'd0, y}, 32'h03);
    step(1, 8'hF0, 8'h3C, 3'd4, 0, 4'd0, 1);
    chk("xor", {24'd0, y}, 32'hCC);
    step(0, 8'h00, 8'h00, 3'd0, 0, 4'd0, 1);

    // reduce NOR len 3
    step(1, 8'h01, 8'h00, 3'd3, 1, 4'd3, 1);
    step(1, 8'h02, 8'h00, 3'd0, 0, 4'd9, 1);
    step(1, 8'h04, 8'h00, 3'd1, 1, 4'd1, 1);
    chk("red_nor", {24'd0, y}, 32'hF8);
    chk("red_nor_op", {29'd0, y_last_op}, 32'd3);

    // reduce XOR len 0 acts as len 1
    step(1, 8'hA5, 8'h00, 3'd4, 1, 4'd0, 1);
    chk("red_len0", {24'd0, y}, 32'hA5);

    // stall five cycles, then stream
    step(1, 8'h5A, 8'h0F, 3'd0, 0, 4'd0, 1);
    y_hold = y;
    for (int i = 0; i < 5; i++) begin
      step(1, 8'hFF, 8'hFF, 3'd1, 0, 4'd0, 0);
    end
    chk("stall_y", {24'd0, y}, {24'd0, y_hold});
    chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      step(1, 8'(i * 17), 8'h33, 3'(i), 0, 4'd0, 1);
    end
    step(0, 8'h00, 8'h00, 3'd0, 0, 4'd0, 1);

    // reset after 2 of 4 beats, then clean AND reduction
    step(1, 8'h0F, 8'h00, 3'd1, 1, 4'd4, 1);
    step(1, 8'hF0, 8'h00, 3'd1, 1, 4'd4, 1);
    async_reset();
    chk("rst_mid_out_valid", {31'd0, out_valid}, 32'd0);
    step(1, 8'hF3, 8'h00, 3'd0, 1, 4'd2, 1);
    step(1, 8'h3F, 8'h00, 3'd0, 1, 4'd2, 1);
    chk("red_after_rst", {24'd0, y}, 32'h33);

    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0, 8'($urandom), 8'($urandom),
           3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
           4'($urandom_range(0, 5)), $urandom_range(0, 3) != 0);
    end
    for (int i = 0; i < 3; i++) begin
      step(0, 8'h00, 8'h00, 3'd0, 0, 4'd0, 1);
    end
    chk("drained", {31'd0, out_valid}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
